mf_sequencer: RTL and testbench

MF_SEQUENCER -- requirements
Module: mf_sequencer

---
 rtl/mf_sequencer.sv | 152 +++++++++++++++
 tb/tb_mf_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mf_sequencer.sv
// Matched-filter run sequencer: coefficient load, settle, data stream, drain, done.
// All outputs come from flops loaded with values decoded from the next state.
module mf_sequencer #(
  parameter int unsigned COEFF_LENGTH  = 10000,
  parameter int unsigned DATA_LENGTH   = 33000,
  parameter int unsigned DRAIN_LENGTH  = 10000,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned SETTLE_LENGTH = 2
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        start,
  input  logic        abort,
  input  logic        coeffDoneFlag,
  output logic        enableCoeffRead,
  output logic        loadCoefficients,
  output logic        enableDataRead,
  output logic        loadDataFlag,
  output logic        stopDataLoadFlag,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] phaseCount,
  output logic [2:0]  state
);

  localparam int unsigned PW = 16;

  localparam logic [PW-1:0] COEFF_LAST  = PW'(COEFF_LENGTH + TIMEOUT - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_LENGTH - 1);
  localparam logic [PW-1:0] DATA_LAST   = PW'(DATA_LENGTH - 1);
  localparam logic [PW-1:0] DRAIN_LAST  = PW'(DRAIN_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd1,
    LOAD_COEFF = 3'd2,
    SETTLE     = 3'd3,
    LOAD_DATA  = 3'd4,
    DRAIN      = 3'd5,
    DONE       = 3'd6,
    ERROR      = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          en_coeff_q, en_coeff_d;
  logic          load_coeff_q, load_coeff_d;
  logic          en_data_q, en_data_d;
  logic          load_data_q, load_data_d;
  logic          stop_q, stop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  // Next state, phase counter and decoded outputs for the next cycle
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q + PW'(1);
    en_coeff_d   = 1'b0;
    load_coeff_d = 1'b0;
    en_data_d    = 1'b0;
    load_data_d  = 1'b0;
    stop_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;

    unique case (state_q)
      IDLE:       if (start) state_d = LOAD_COEFF;
      LOAD_COEFF: begin
        if (coeffDoneFlag)             state_d = SETTLE;
        else if (phase_q == COEFF_LAST) state_d = ERROR;
      end
      SETTLE:     if (phase_q == SETTLE_LAST) state_d = LOAD_DATA;
      LOAD_DATA:  if (phase_q == DATA_LAST)   state_d = DRAIN;
      DRAIN:      if (phase_q == DRAIN_LAST)  state_d = DONE;
      DONE:       state_d = IDLE;
      ERROR:      state_d = ERROR;
      default:    state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;

    // Counter only runs within the timed phases and restarts on every entry
    if ((state_d != state_q) || (state_d == IDLE) || (state_d == DONE) ||
        (state_d == ERROR)) begin
      phase_d = '0;
    end

    unique case (state_d)
      LOAD_COEFF: begin
        en_coeff_d   = 1'b1;
        load_coeff_d = 1'b1;
        busy_d       = 1'b1;
      end
      SETTLE:     busy_d = 1'b1;
      LOAD_DATA: begin
        en_data_d   = 1'b1;
        load_data_d = 1'b1;
        busy_d      = 1'b1;
      end
      DRAIN: begin
        stop_d = 1'b1;
        busy_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      ERROR:      error_d = 1'b1;
      default:    busy_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      en_coeff_q   <= 1'b0;
      load_coeff_q <= 1'b0;
      en_data_q    <= 1'b0;
      load_data_q  <= 1'b0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      en_coeff_q   <= en_coeff_d;
      load_coeff_q <= load_coeff_d;
      en_data_q    <= en_data_d;
      load_data_q  <= load_data_d;
      stop_q       <= stop_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign enableCoeffRead  = en_coeff_q;
  assign loadCoefficients = load_coeff_q;
  assign enableDataRead   = en_data_q;
  assign loadDataFlag     = load_data_q;
  assign stopDataLoadFlag = stop_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign phaseCount       = phase_q;
  assign state            = state_q;

endmodule

// File: tb/tb_mf_sequencer.sv
// Self-checking bench for mf_sequencer: expected per-cycle timelines are built
// from phase lengths and compared against every output each cycle.
module tb_mf_sequencer;

  localparam int unsigned CL  = 4;
  localparam int unsigned DL  = 8;
  localparam int unsigned DRL = 4;
  localparam int unsigned TO  = 3;
  localparam int unsigned SL  = 2;

  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_LC   = 3'd2;
  localparam logic [2:0] S_ST   = 3'd3;
  localparam logic [2:0] S_LD   = 3'd4;
  localparam logic [2:0] S_DR   = 3'd5;
  localparam logic [2:0] S_DN   = 3'd6;
  localparam logic [2:0] S_ER   = 3'd7;

  logic        clock = 1'b0;
  logic        resetN = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        coeffDoneFlag = 1'b0;
  logic        enableCoeffRead, loadCoefficients, enableDataRead, loadDataFlag;
  logic        stopDataLoadFlag, busy, done, error;
  logic [15:0] phaseCount;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] ph;
  } ent_t;

  ent_t sched[$];

  mf_sequencer #(
    .COEFF_LENGTH(CL), .DATA_LENGTH(DL), .DRAIN_LENGTH(DRL),
    .TIMEOUT(TO), .SETTLE_LENGTH(SL)
  ) dut (
    .clock(clock), .resetN(resetN), .start(start), .abort(abort),
    .coeffDoneFlag(coeffDoneFlag), .enableCoeffRead(enableCoeffRead),
    .loadCoefficients(loadCoefficients), .enableDataRead(enableDataRead),
    .loadDataFlag(loadDataFlag), .stopDataLoadFlag(stopDataLoadFlag),
    .busy(busy), .done(done), .error(error), .phaseCount(phaseCount),
    .state(state)
  );

  always #5 clock = ~clock;

  // {enC, loadC, enD, loadD, stop, busy, done, error, phase, state}
  function automatic logic [26:0] exp_vec(input logic [2:0] st, input logic [15:0] ph);
    logic [7:0] f;
    case (st)
      S_LC:    f = 8'b1100_0100;
      S_ST:    f = 8'b0000_0100;
      S_LD:    f = 8'b0011_0100;
      S_DR:    f = 8'b0000_1100;
      S_DN:    f = 8'b0000_0110;
      S_ER:    f = 8'b0000_0001;
      default: f = 8'b0000_0000;
    endcase
    return {f, ph, st};
  endfunction

  function automatic logic [26:0] obs_vec();
    return {enableCoeffRead, loadCoefficients, enableDataRead, loadDataFlag,
            stopDataLoadFlag, busy, done, error, phaseCount, state};
  endfunction

  task automatic append(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) sched.push_back({st, 16'(i)});
  endtask

  // Timeline of a run whose coefficient reader finishes in LOAD_COEFF cycle k
  task automatic build_run(input int k);
    sched.delete();
    if (k <= int'(CL + TO)) begin
      append(S_LC, k);
      append(S_ST, SL);
      append(S_LD, DL);
      append(S_DR, DRL);
      append(S_DN, 1);
      append(S_IDLE, 1);
    end else begin
      append(S_LC, CL + TO);
      append(S_ER, 1);
    end
  endtask

  task automatic test_reset();
    #1 resetN = 1'b0;
    #1;
    vectors++;
    if (obs_vec() !== exp_vec(S_IDLE, 16'd0)) begin
      miscompares++;
      $display("FAIL reset_async: got %h want %h", obs_vec(), exp_vec(S_IDLE, 16'd0));
    end
    @(posedge clock); #1;
    vectors++;
    if (obs_vec() !== exp_vec(S_IDLE, 16'd0)) begin
      miscompares++;
      $display("FAIL reset_held: got %h want %h", obs_vec(), exp_vec(S_IDLE, 16'd0));
    end
    start  = 1'b1;
    resetN = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    vectors++;
    if (obs_vec() !== exp_vec(S_LC, 16'd0)) begin
      miscompares++;
      $display("FAIL first_start: got %h want %h", obs_vec(), exp_vec(S_LC, 16'd0));
    end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    vectors++;
    if (obs_vec() !== exp_vec(S_IDLE, 16'd0)) begin
      miscompares++;
      $display("FAIL abort_coeff: got %h want %h", obs_vec(), exp_vec(S_IDLE, 16'd0));
    end
  endtask

  // Full run with ignored start/coeffDoneFlag noise; start is held during DRAIN
  task automatic test_run(input int k);
    build_run(k);
    start = 1'b1;
    for (int i = 0; i < sched.size(); i++) begin
      @(posedge clock); #1;
      vectors++;
      if (obs_vec() !== exp_vec(sched[i].st, sched[i].ph)) begin
        miscompares++;
        $display("FAIL run k=%0d cyc=%0d: got %h want %h", k, i, obs_vec(),
                 exp_vec(sched[i].st, sched[i].ph));
      end
      if (i == sched.size() - 1) begin
        start = 1'b0;
        coeffDoneFlag = 1'b0;
      end else begin
        start = (sched[i].st == S_DR) ? 1'b1 : 1'($urandom_range(0, 1));
        if (sched[i].st == S_LC) coeffDoneFlag = (sched[i].ph == 16'(k - 1));
        else                     coeffDoneFlag = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_timeout();
    test_run(int'(CL + TO) + 1);
    start = 1'b1;
    coeffDoneFlag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      vectors++;
      if (obs_vec() !== exp_vec(S_ER, 16'd0)) begin
        miscompares++;
        $display("FAIL error_hold cyc=%0d: got %h want %h", i, obs_vec(), exp_vec(S_ER, 16'd0));
      end
    end
    start = 1'b0;
    coeffDoneFlag = 1'b0;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    vectors++;
    if (obs_vec() !== exp_vec(S_IDLE, 16'd0)) begin
      miscompares++;
      $display("FAIL error_abort: got %h want %h", obs_vec(), exp_vec(S_IDLE, 16'd0));
    end
  endtask

  task automatic test_abort();
    int k;
    k = int'($urandom_range(1, CL));
    build_run(k);
    start = 1'b1;
    for (int i = 0; i < sched.size(); i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      vectors++;
      if (obs_vec() !== exp_vec(sched[i].st, sched[i].ph)) begin
        miscompares++;
        $display("FAIL abort_pre cyc=%0d: got %h want %h", i, obs_vec(),
                 exp_vec(sched[i].st, sched[i].ph));
      end
      coeffDoneFlag = (sched[i].st == S_LC) && (sched[i].ph == 16'(k - 1));
      if (sched[i].st == S_LD && sched[i].ph == 16'd5) break;
    end
    coeffDoneFlag = 1'b0;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    for (int i = 0; i < int'(DL + DRL); i++) begin
      vectors++;
      if (obs_vec() !== exp_vec(S_IDLE, 16'd0)) begin
        miscompares++;
        $display("FAIL abort_idle cyc=%0d: got %h want %h", i, obs_vec(), exp_vec(S_IDLE, 16'd0));
      end
      @(posedge clock); #1;
    end
    test_run(int'(CL));
  endtask

  task automatic test_simultaneous();
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      vectors++;
      if (obs_vec() !== exp_vec(S_IDLE, 16'd0)) begin
        miscompares++;
        $display("FAIL start_abort cyc=%0d: got %h want %h", i, obs_vec(), exp_vec(S_IDLE, 16'd0));
      end
    end
    start = 1'b0;
    abort = 1'b0;
    test_run(int'(CL));
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      vectors++;
      if (obs_vec() !== exp_vec(S_IDLE, 16'd0)) begin
        miscompares++;
        $display("FAIL no_requeue cyc=%0d: got %h want %h", i, obs_vec(), exp_vec(S_IDLE, 16'd0));
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    build_run(int'(CL));
    start = 1'b1;
    for (int i = 0; i < sched.size(); i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      vectors++;
      if (obs_vec() !== exp_vec(sched[i].st, sched[i].ph)) begin
        miscompares++;
        $display("FAIL drain_pre cyc=%0d: got %h want %h", i, obs_vec(),
                 exp_vec(sched[i].st, sched[i].ph));
      end
      coeffDoneFlag = (sched[i].st == S_LC) && (sched[i].ph == 16'(CL - 1));
      if (sched[i].st == S_DR && sched[i].ph == 16'd1) break;
    end
    coeffDoneFlag = 1'b0;
    #2 resetN = 1'b0;
    #1;
    vectors++;
    if (obs_vec() !== exp_vec(S_IDLE, 16'd0)) begin
      miscompares++;
      $display("FAIL reset_drain_async: got %h want %h", obs_vec(), exp_vec(S_IDLE, 16'd0));
    end
    #4 resetN = 1'b1;
    for (int i = 0; i < int'(DRL) + 2; i++) begin
      @(posedge clock); #1;
      vectors++;
      if (obs_vec() !== exp_vec(S_IDLE, 16'd0)) begin
        miscompares++;
        $display("FAIL reset_drain_idle cyc=%0d: got %h want %h", i, obs_vec(),
                 exp_vec(S_IDLE, 16'd0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_run(int'(CL));
    for (int r = 0; r < 6; r++) test_run(int'($urandom_range(1, CL + TO)));
    test_timeout();
    test_abort();
    test_simultaneous();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
